// File: rtl/controller_pkg.sv
// controller_pkg: shared types and constants for the controller bus arbiter.
//   ctrl_arb_state_e : arbiter FSM state encoding
//   ArbGuardCycles   : default number of released-bus cycles after an ownership
//   pick_winner      : round-robin winner selection between the two engines
package controller_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitFree,
        StOwn,
        StRelease
    } ctrl_arb_state_e;

    localparam int unsigned ArbGuardCycles = 2;

    // Engine index: 0 = I2C, 1 = I3C. On a tie the engine that did not own the
    // bus last time wins; a single request simply wins.
    function automatic logic pick_winner(input logic [1:0] req, input logic last_owner);
        if (req == 2'b11) begin
            return ~last_owner;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/ctrl_bus_free_timer.sv
// ctrl_bus_free_timer: bus-free hold-off counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : load load_val_i (arbitration starting)
//   run_i         : counting phase active
//   free_i        : bus monitor reports bus free this cycle
//   load_val_i    : hold-off length in cycles
//   expired_o     : counter has reached zero
// While running, a busy cycle reloads the counter so the hold-off always
// measures consecutive free cycles. The counter saturates at zero.
module ctrl_bus_free_timer #(
    parameter int unsigned TimerWidth = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  run_i,
    input  logic                  free_i,
    input  logic [TimerWidth-1:0] load_val_i,
    output logic                  expired_o
);

    logic [TimerWidth-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = load_val_i;
        end else if (run_i) begin
            if (!free_i) begin
                count_d = load_val_i;
            end else if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/ctrl_bus_arbiter.sv
// ctrl_bus_arbiter: arbitrates PHY ownership between the I2C engine (index 0)
// and the I3C engine (index 1), sitting between the engines and the PHY.
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   enable_i                      : active-controller mode enable
//   req_i[1:0], done_i[1:0]       : per-engine request / transfer complete
//   eng_scl_i, eng_sda_i,
//   eng_sel_od_pp_i [1:0]         : per-engine PHY drive
//   bus_free_i                    : bus monitor idle indication
//   t_bus_free_i                  : required consecutive free cycles before grant
//   gnt_o[1:0]                    : registered one-hot grant (or zero)
//   phy_scl_o, phy_sda_o,
//   phy_sel_od_pp_o               : muxed PHY drive, released outside ownership
//   busy_o                        : arbiter not idle
module ctrl_bus_arbiter
    import controller_pkg::*;
#(
    parameter int unsigned TimerWidth  = 20,
    parameter int unsigned GuardCycles = ArbGuardCycles
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [1:0]            req_i,
    input  logic [1:0]            done_i,
    input  logic [1:0]            eng_scl_i,
    input  logic [1:0]            eng_sda_i,
    input  logic [1:0]            eng_sel_od_pp_i,
    input  logic                  bus_free_i,
    input  logic [TimerWidth-1:0] t_bus_free_i,
    output logic [1:0]            gnt_o,
    output logic                  phy_scl_o,
    output logic                  phy_sda_o,
    output logic                  phy_sel_od_pp_o,
    output logic                  busy_o
);

    localparam int unsigned GuardW = (GuardCycles > 1) ? $clog2(GuardCycles) : 1;
    localparam logic [GuardW-1:0] GuardLast =
        (GuardCycles > 0) ? GuardW'(GuardCycles - 1) : '0;

    ctrl_arb_state_e   state_q;
    logic              winner_q;
    logic              last_owner_q;
    logic [1:0]        gnt_q;
    logic [GuardW-1:0] guard_q;

    logic start;
    logic win_req;
    logic win_done;
    logic timer_start;
    logic timer_run;
    logic timer_expired;
    logic own;

    assign start       = enable_i && (req_i != 2'b00);
    assign win_req     = req_i[winner_q];
    assign win_done    = done_i[winner_q];
    assign timer_start = (state_q == StIdle) && start;
    assign timer_run   = (state_q == StWaitFree);

    ctrl_bus_free_timer #(
        .TimerWidth (TimerWidth)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (timer_start),
        .run_i      (timer_run),
        .free_i     (bus_free_i),
        .load_val_i (t_bus_free_i),
        .expired_o  (timer_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            winner_q     <= 1'b0;
            last_owner_q <= 1'b1;
            gnt_q        <= 2'b00;
            guard_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        winner_q <= pick_winner(req_i, last_owner_q);
                        state_q  <= StWaitFree;
                    end
                end
                StWaitFree: begin
                    // Abort takes priority over a grant on the same edge.
                    if (!enable_i || !win_req) begin
                        state_q <= StIdle;
                    end else if (bus_free_i && timer_expired) begin
                        state_q <= StOwn;
                        gnt_q   <= {winner_q, ~winner_q};
                    end
                end
                StOwn: begin
                    // enable_i is deliberately ignored: a transfer in flight completes.
                    if (win_done || !win_req) begin
                        gnt_q        <= 2'b00;
                        last_owner_q <= winner_q;
                        if (GuardCycles == 0) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StRelease;
                            guard_q <= GuardLast;
                        end
                    end
                end
                StRelease: begin
                    if (guard_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        guard_q <= guard_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    // Derived from registered state only, so an asynchronous reset releases the
    // PHY immediately.
    assign own             = (state_q == StOwn);
    assign phy_scl_o       = own ? eng_scl_i[winner_q]       : 1'b1;
    assign phy_sda_o       = own ? eng_sda_i[winner_q]       : 1'b1;
    assign phy_sel_od_pp_o = own ? eng_sel_od_pp_i[winner_q] : 1'b0;
    assign busy_o          = (state_q != StIdle);
    assign gnt_o           = gnt_q;

endmodule

// File: tb/tb_ctrl_bus_arbiter.sv
// Directed bench for ctrl_bus_arbiter. Observed vector layout:
// {busy, gnt[1:0], phy_scl, phy_sda, phy_sel_od_pp}.
module tb_ctrl_bus_arbiter;

    localparam int unsigned TimerWidth = 20;

    // Engine 0 drives scl=0 sda=1 sel=0; engine 1 drives scl=1 sda=0 sel=1.
    localparam logic [5:0] VecIdle = 6'b0_00_110;
    localparam logic [5:0] VecWait = 6'b1_00_110;
    localparam logic [5:0] VecOwn0 = 6'b1_01_010;
    localparam logic [5:0] VecOwn1 = 6'b1_10_101;

    typedef struct {
        string      tag;
        logic [5:0] exp;
    } sb_item_t;

    logic                  clk_i;
    logic                  rst_ni;
    logic                  enable_i;
    logic [1:0]            req_i;
    logic [1:0]            done_i;
    logic [1:0]            eng_scl_i;
    logic [1:0]            eng_sda_i;
    logic [1:0]            eng_sel_od_pp_i;
    logic                  bus_free_i;
    logic [TimerWidth-1:0] t_bus_free_i;
    logic [1:0]            gnt_o;
    logic                  phy_scl_o;
    logic                  phy_sda_o;
    logic                  phy_sel_od_pp_o;
    logic                  busy_o;

    int checks = 0;
    int errors = 0;
    sb_item_t sb_q[$];

    ctrl_bus_arbiter #(
        .TimerWidth  (TimerWidth),
        .GuardCycles (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .enable_i        (enable_i),
        .req_i           (req_i),
        .done_i          (done_i),
        .eng_scl_i       (eng_scl_i),
        .eng_sda_i       (eng_sda_i),
        .eng_sel_od_pp_i (eng_sel_od_pp_i),
        .bus_free_i      (bus_free_i),
        .t_bus_free_i    (t_bus_free_i),
        .gnt_o           (gnt_o),
        .phy_scl_o       (phy_scl_o),
        .phy_sda_o       (phy_sda_o),
        .phy_sel_od_pp_o (phy_sel_od_pp_o),
        .busy_o          (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [5:0] obs();
        return {busy_o, gnt_o, phy_scl_o, phy_sda_o, phy_sel_od_pp_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input string tag, input logic [5:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic pop_check();
        sb_item_t it;
        logic [5:0] o;
        o  = obs();
        it = sb_q.pop_front();
        checks++;
        assert (o === it.exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", it.tag, o, it.exp);
        end
    endtask

    // Steps until a grant appears (bounded) and checks latency and grant value.
    task automatic wait_grant(input int exp_steps, input logic [1:0] exp_gnt,
                              input string tag);
        int n;
        n = 0;
        while (gnt_o == 2'b00 && n < 50) begin
            step();
            n++;
        end
        checks++;
        assert (n === exp_steps) else begin
            errors++;
            $error("FAIL %s_latency: observed %0d expected %0d", tag, n, exp_steps);
        end
        checks++;
        assert (gnt_o === exp_gnt) else begin
            errors++;
            $error("FAIL %s_gnt: observed %b expected %b", tag, gnt_o, exp_gnt);
        end
    endtask

    // Grant is never two-hot and is only nonzero while busy.
    always @(negedge clk_i) begin
        checks++;
        assert ((gnt_o !== 2'b11) && ((gnt_o === 2'b00) || (busy_o === 1'b1))) else begin
            errors++;
            $error("FAIL gnt_invariant: observed gnt=%b busy=%b expected legal", gnt_o, busy_o);
        end
    end

    initial begin
        rst_ni          = 1'b0;
        enable_i        = 1'b1;
        req_i           = 2'b00;
        done_i          = 2'b00;
        eng_scl_i       = 2'b10;
        eng_sda_i       = 2'b01;
        eng_sel_od_pp_i = 2'b10;
        bus_free_i      = 1'b1;
        t_bus_free_i    = 20'd3;
        #3;
        push("reset_state", VecIdle);
        pop_check();
        step();
        rst_ni = 1'b1;

        // Single request, hold-off 3: grant 5 edges after req.
        req_i = 2'b01;
        push("a_wait", VecWait);
        step();
        pop_check();
        push("a_pre_gnt", VecWait);
        repeat (3) step();
        pop_check();
        push("a_gnt", VecOwn0);
        step();
        pop_check();
        eng_scl_i = 2'b11;
        push("a_scl_follow", 6'b1_01_110);
        #1;
        pop_check();
        eng_scl_i = 2'b10;
        done_i = 2'b01;
        push("a_release1", VecWait);
        step();
        pop_check();
        done_i = 2'b00;
        req_i  = 2'b00;
        push("a_release2", VecWait);
        step();
        pop_check();
        push("a_idle", VecIdle);
        step();
        pop_check();

        // Tie from reset: engine 0 first, engine 1 after done and guard.
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        t_bus_free_i = 20'd2;
        req_i = 2'b11;
        wait_grant(4, 2'b01, "b_gnt0");
        done_i = 2'b01;
        step();
        done_i = 2'b00;
        wait_grant(6, 2'b10, "b_gnt1");
        push("b_own1", VecOwn1);
        pop_check();
        req_i = 2'b00;
        repeat (3) step();
        push("b_idle", VecIdle);
        pop_check();

        // Hold-off restarts after a busy glitch.
        t_bus_free_i = 20'd4;
        req_i = 2'b01;
        repeat (3) step();
        bus_free_i = 1'b0;
        step();
        bus_free_i = 1'b1;
        wait_grant(5, 2'b01, "c_gnt");
        req_i = 2'b00;
        repeat (3) step();
        push("c_idle", VecIdle);
        pop_check();

        // enable_i drop during ownership does not abort; no regrant while disabled.
        t_bus_free_i = 20'd0;
        req_i = 2'b01;
        wait_grant(2, 2'b01, "d_gnt");
        enable_i = 1'b0;
        repeat (2) step();
        push("d_hold", VecOwn0);
        pop_check();
        done_i = 2'b01;
        step();
        done_i = 2'b00;
        repeat (3) step();
        push("d_no_regrant", VecIdle);
        pop_check();
        enable_i = 1'b1;
        req_i = 2'b00;
        step();

        // Asynchronous reset during ownership releases the bus immediately.
        req_i = 2'b10;
        wait_grant(2, 2'b10, "e_gnt");
        push("e_own_sda_low", VecOwn1);
        pop_check();
        rst_ni = 1'b0;
        #1;
        push("e_async_rst", VecIdle);
        pop_check();
        req_i = 2'b00;
        rst_ni = 1'b1;
        step();

        // Request withdrawn while waiting for the bus.
        t_bus_free_i = 20'd5;
        req_i = 2'b01;
        step();
        push("f_wait", VecWait);
        pop_check();
        step();
        req_i = 2'b00;
        step();
        push("f_abort", VecIdle);
        pop_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
